vu_rom_sequencer: RTL
=====================

Name: vu_rom_sequencer

Overview:
- Frame controller that sequences the 256x24 colour ROM (registered read, 1-cycle latency, read enable) for the VU meter LED bar.
- On each start it reads one palette bank of NUM_LEDS entries, masks LEDs above the current VU level to black and applies a brightness shift.
- Streams the resulting GRB/RGB pixels over a valid/ready handshake to the downstream LED serializer.
- Sole master of the ROM address/enable port.

Parameters:
- NUM_LEDS, 16, LEDs per frame and entries per palette bank (power of 2, ≤ 256).
- ADDR_W, 8, ROM address width.
- DATA_W, 24, ROM word / pixel width (3 x 8-bit channels).
- LVL_W, 5, level width, equal to clog2(NUM_LEDS+1).
- BANK_W, 4, bank select width, equal to ADDR_W − log2(NUM_LEDS).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  single-cycle frame request; sampled only in IDLE.
- i_level  in  LVL_W  number of lit LEDs; latched on accepted start.
- i_bank  in  BANK_W  palette bank; latched on accepted start.
- i_dim  in  2  brightness right-shift per channel (0..3); latched on accepted start.
- o_rom_addr  out  ADDR_W  ROM address.
- o_rom_ren  out  1  ROM read enable.
- i_rom_data  in  DATA_W  ROM data, valid the cycle after o_rom_ren=1.
- o_pix  out  DATA_W  pixel data.
- o_pix_valid  out  1  pixel valid.
- i_pix_ready  in  1  downstream accept.
- o_busy  out  1  high from accepted start until the frame-done cycle, inclusive.
- o_done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): state IDLE; all outputs 0; index, latched level, bank and dim cleared. Applies mid-frame too: the frame is abandoned with no done pulse, and o_pix_valid drops on the next edge.
- States:
  - IDLE: o_busy=0. When i_start=1, latch level/bank/dim, set idx=0, go to FETCH. o_busy rises in the same cycle as FETCH.
  - FETCH: o_rom_ren=1, o_rom_addr={bank_q, idx}. Next state is CAPTURE.
  - CAPTURE: o_rom_ren=0. Register pix = mask(i_rom_data). Next state is SEND.
  - SEND: o_pix_valid=1 and o_pix stable until i_pix_ready=1.
    - On handshake, if idx==NUM_LEDS-1, go to DONE; otherwise idx+1 and go to FETCH.
  - DONE: o_done=1 and o_busy=1 for one cycle, then IDLE.
- Timing: 3 cycles per pixel minimum. Start-to-first-valid is 3 edges. A frame with ready tied high lasts 3*NUM_LEDS+1 cycles after start.
- Mask/dim rule:
  - If idx < level_q, each 8-bit channel is ch >> dim_q; otherwise the pixel is 24'h000000.
  - level_q ≥ NUM_LEDS saturates to all lit.
  - level 0 still performs every ROM read, giving uniform frame timing.
- o_rom_ren is never high outside FETCH. o_rom_addr holds its last value when not reading.
- i_start while busy (including DONE) is ignored, with no queuing. i_level/i_bank/i_dim changes mid-frame have no effect.
- o_pix_valid may not drop without a handshake (except on reset). i_pix_ready while valid=0 is ignored.
- idx does not wrap within a frame. Bank addressing never crosses a bank boundary.

Decomposition:
- Package vu_pkg:
  - constants NUM_LEDS, DATA_W, ADDR_W, LVL_W, BANK_W
  - state enum {IDLE, FETCH, CAPTURE, SEND, DONE}
  - channel width 8
- Sub-module pix_shade: combinational mask + per-channel shift (inputs data, idx, level, dim). Keeps the FSM file focused on sequencing.

Test Plan:
- Reset then idle, ready=1, ROM = address-as-data pattern; start with level=16, bank=2, dim=0 -> ROM addresses 0x20..0x2F each read once; pixels 0x000020..0x00002F in order; o_done 49 cycles after start; busy falls the cycle after.
- level=5, bank=0, dim=1, ROM[0..15]=24'hFF8040 -> pixels 0..4 = 24'h7F4020, pixels 5..15 = 0; exactly 16 ROM reads.
- Backpressure: ready low for 7 cycles on pixel 3, random thereafter -> o_pix stable and valid held while stalled; no extra ROM reads; all 16 pixels in order.
- i_start pulsed during pixel 8 with different bank/level -> ignored, frame unchanged; a new start after o_done begins a new frame.
- Reset asserted during SEND of pixel 10 -> next edge: valid=0, busy=0, ren=0, no done; a fresh start re-reads from idx 0.
- level=0 and level=31 -> all-black frame / all-lit frame respectively, both 16 reads, same timing.

Source files
------------

// File: rtl/vu_pkg.sv
// Shared constants and FSM state type for the VU meter ROM sequencer.
package vu_pkg;

  localparam int NUM_LEDS = 16;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 24;
  localparam int LVL_W    = $clog2(NUM_LEDS + 1);
  localparam int IDX_W    = $clog2(NUM_LEDS);
  localparam int BANK_W   = ADDR_W - IDX_W;
  localparam int CH_W     = 8;
  localparam int NUM_CH   = DATA_W / CH_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/pix_shade.sv
// Combinational pixel shader: blanks LEDs at or above the level, dims lit ones.
module pix_shade #(
  parameter int DATA_W = vu_pkg::DATA_W,
  parameter int LVL_W  = vu_pkg::LVL_W,
  parameter int IDX_W  = vu_pkg::IDX_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LVL_W-1:0]  i_level,
  input  logic [1:0]        i_dim,
  output logic [DATA_W-1:0] o_pix
);
  import vu_pkg::*;

  logic lit;

  // Levels of NUM_LEDS or more naturally saturate because idx never exceeds NUM_LEDS-1.
  assign lit = (LVL_W'(i_idx) < i_level);

  for (genvar gi = 0; gi < DATA_W / CH_W; gi++) begin : g_ch
    assign o_pix[gi*CH_W +: CH_W] = lit ? (i_data[gi*CH_W +: CH_W] >> i_dim) : '0;
  end

endmodule

// File: rtl/vu_rom_sequencer.sv
// Frame controller: walks one palette bank of the colour ROM, shades each entry
// and streams the pixels to the LED serializer over valid/ready.
module vu_rom_sequencer #(
  parameter int NUM_LEDS = vu_pkg::NUM_LEDS,
  parameter int ADDR_W   = vu_pkg::ADDR_W,
  parameter int DATA_W   = vu_pkg::DATA_W,
  parameter int LVL_W    = vu_pkg::LVL_W,
  parameter int BANK_W   = vu_pkg::BANK_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LVL_W-1:0]  i_level,
  input  logic [BANK_W-1:0] i_bank,
  input  logic [1:0]        i_dim,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_rom_ren,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_pix,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_busy,
  output logic              o_done
);
  import vu_pkg::*;

  localparam int SEQ_IDX_W = ADDR_W - BANK_W;
  localparam logic [SEQ_IDX_W-1:0] LAST_IDX = SEQ_IDX_W'(NUM_LEDS - 1);

  state_e                state_q;
  logic [SEQ_IDX_W-1:0]  idx_q;
  logic [SEQ_IDX_W-1:0]  idx_d;
  logic [LVL_W-1:0]      level_q;
  logic [BANK_W-1:0]     bank_q;
  logic [1:0]            dim_q;
  logic [ADDR_W-1:0]     rom_addr_q;
  logic                  rom_ren_q;
  logic [DATA_W-1:0]     pix_q;
  logic [DATA_W-1:0]     pix_d;
  logic                  pix_valid_q;
  logic                  busy_q;
  logic                  done_q;

  assign idx_d = idx_q + 1'b1;

  pix_shade #(
    .DATA_W (DATA_W),
    .LVL_W  (LVL_W),
    .IDX_W  (SEQ_IDX_W)
  ) u_shade (
    .i_data  (i_rom_data),
    .i_idx   (idx_q),
    .i_level (level_q),
    .i_dim   (dim_q),
    .o_pix   (pix_d)
  );

  // Read enable and address are issued on the edge entering FETCH so they are registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      level_q     <= '0;
      bank_q      <= '0;
      dim_q       <= '0;
      rom_addr_q  <= '0;
      rom_ren_q   <= 1'b0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            level_q    <= i_level;
            bank_q     <= i_bank;
            dim_q      <= i_dim;
            idx_q      <= '0;
            rom_addr_q <= {i_bank, {SEQ_IDX_W{1'b0}}};
            rom_ren_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          rom_ren_q <= 1'b0;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          pix_q       <= pix_d;
          pix_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (i_pix_ready) begin
            pix_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q      <= idx_d;
              rom_addr_q <= {bank_q, idx_d};
              rom_ren_q  <= 1'b1;
              state_q    <= FETCH;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rom_addr  = rom_addr_q;
  assign o_rom_ren   = rom_ren_q;
  assign o_pix       = pix_q;
  assign o_pix_valid = pix_valid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
